// File: rtl/decoder_select_arbiter_pkg.sv
// Shared constants for the decoder select arbiter and its round-robin picker.
// State encodings are plain constants so older tools can read them directly.
package decoder_select_arbiter_pkg;

    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_GRANT = 2'd1;
    localparam state_t ST_GAP   = 2'd2;

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin pick over 16 requesters: rotate by ptr,
// find the lowest set bit, then rotate the index back.
module rr_pick16
    import decoder_select_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic [NUM_REQ-1:0] rotated;
    logic [SEL_W-1:0]   offset;

    always_comb begin
        rotated = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rotated[i] = req[SEL_W'(i) + ptr];
        end
    end

    // Scanning downward leaves the lowest set offset, i.e. the first requester at or after ptr.
    always_comb begin
        offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = SEL_W'(i);
            end
        end
    end

    assign idx = offset + ptr;
    assign any = |req;

endmodule

// File: rtl/decoder_select_arbiter.sv
// Round-robin owner of the shared 4-to-16 decoder select: grants one requester,
// holds it until release or hold timeout, then inserts a dead cycle before the next owner.
module decoder_select_arbiter
    import decoder_select_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [SEL_W-1:0]   select,
    output logic               grant_valid,
    output logic               timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
    localparam logic             TIMEOUT_EN = (HOLD_MAX != 0);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             hold_hit;
    logic             release_now;

    rr_pick16 u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign cnt_next    = cnt + CNT_W'(1);
    assign hold_hit    = TIMEOUT_EN && (cnt == HOLD_LAST);
    assign release_now = done || !req[select] || hold_hit;

    // timeout is registered, so it is raised one edge early to coincide with the last granted cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            select      <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            ptr         <= '0;
            cnt         <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        select      <= pick_idx;
                        grant_valid <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_GRANT;
                        timeout     <= TIMEOUT_EN && (HOLD_LAST == '0);
                    end
                end
                ST_GRANT: begin
                    cnt <= cnt_next;
                    if (release_now) begin
                        grant_valid <= 1'b0;
                        ptr         <= select + SEL_W'(1);
                        state       <= ST_GAP;
                    end else begin
                        timeout <= TIMEOUT_EN && (cnt_next == HOLD_LAST);
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state       <= ST_IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_select_arbiter.sv
// Scoreboard bench: stimulus queues expected grants, a negedge monitor
// measures each finished grant and compares it against the queue head.
module tb_decoder_select_arbiter;

    typedef struct {
        int sel;
        int len;
        int tmo_pos;
    } grant_t;

    logic        clk;
    logic        reset;
    logic [15:0] req;
    logic        done;
    logic [3:0]  select;
    logic        grant_valid;
    logic        timeout;

    logic [15:0] req_b;
    logic        done_b;
    logic [3:0]  select_b;
    logic        grant_valid_b;
    logic        timeout_b;

    grant_t exp_q[$];
    grant_t got;
    int     checks   = 0;
    int     failures = 0;

    logic   gv_prev = 1'b0;
    int     mon_sel;
    int     mon_len;
    int     mon_tmo_pos;
    int     mon_tmo_cnt;

    decoder_select_arbiter #(.HOLD_MAX(4), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .select      (select),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    decoder_select_arbiter #(.HOLD_MAX(0), .CNT_W(4)) dut_nohold (
        .clk         (clk),
        .reset       (reset),
        .req         (req_b),
        .done        (done_b),
        .select      (select_b),
        .grant_valid (grant_valid_b),
        .timeout     (timeout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] r, input logic d);
        req  = r;
        done = d;
    endtask

    task automatic expectGrant(input int s, input int len, input int tmo_pos);
        grant_t g;
        g.sel     = s;
        g.len     = len;
        g.tmo_pos = tmo_pos;
        exp_q.push_back(g);
    endtask

    task automatic waitGrant(output int waited);
        waited = 0;
        while (!grant_valid && waited < 40) begin
            tick();
            waited++;
        end
        if (!grant_valid) checkOutput("grant_wait_expired", 0, 1);
    endtask

    // Each completed grant is measured here: owner, length, and where timeout pulsed.
    always @(negedge clk) begin
        if (grant_valid) begin
            if (!gv_prev) begin
                mon_sel     = select;
                mon_len     = 0;
                mon_tmo_pos = 0;
                mon_tmo_cnt = 0;
            end
            mon_len++;
            if (select != mon_sel) checkOutput("select_stable", select, mon_sel);
            if (timeout) begin
                mon_tmo_cnt++;
                mon_tmo_pos = mon_len;
            end
        end else begin
            if (timeout) checkOutput("timeout_outside_grant", 1, 0);
            if (gv_prev) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_grant", mon_sel, -1);
                end else begin
                    got = exp_q.pop_front();
                    checkOutput("grant_select", mon_sel, got.sel);
                    checkOutput("grant_length", mon_len, got.len);
                    checkOutput("timeout_position", mon_tmo_pos, got.tmo_pos);
                    checkOutput("timeout_pulses", mon_tmo_cnt, (got.tmo_pos != 0) ? 1 : 0);
                end
            end
        end
        gv_prev = grant_valid;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int rr_exp[5];
        logic any_gv;
        logic bad_gv;
        logic bad_tmo;
        logic bad_sel;

        rr_exp = '{0, 5, 10, 15, 0};

        reset  = 1'b1;
        req    = '0;
        done   = 1'b0;
        req_b  = '0;
        done_b = 1'b0;
        repeat (3) tick();
        checkOutput("reset_select", select, 0);
        checkOutput("reset_grant_valid", grant_valid, 0);
        checkOutput("reset_timeout", timeout, 0);
        checkOutput("reset_nohold_grant_valid", grant_valid_b, 0);
        reset = 1'b0;

        // Reset in the middle of a grant, then re-arbitration one cycle later.
        applyStimulus(16'h0020, 1'b0);
        waitGrant(waited);
        checkOutput("first_select", select, 5);
        expectGrant(5, 1, 0);
        reset = 1'b1;
        tick();
        checkOutput("midgrant_reset_select", select, 0);
        checkOutput("midgrant_reset_grant_valid", grant_valid, 0);
        checkOutput("midgrant_reset_timeout", timeout, 0);
        reset = 1'b0;
        tick();
        checkOutput("post_reset_grant_valid", grant_valid, 1);
        checkOutput("post_reset_select", select, 5);
        expectGrant(5, 1, 0);
        applyStimulus(16'h0000, 1'b1);
        tick();
        applyStimulus(16'h0000, 1'b0);

        // A fresh reset must put the pointer back at 0 before the round-robin run.
        applyStimulus(16'h8421, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            waitGrant(waited);
            if (i > 0) checkOutput("rr_gap_cycles", waited, 2);
            checkOutput("rr_select", select, rr_exp[i]);
            expectGrant(rr_exp[i], 2, 0);
            tick();
            applyStimulus(16'h8421, 1'b1);
            tick();
            applyStimulus((i == 4) ? 16'h0000 : 16'h8421, 1'b0);
        end

        // Pointer wrap from 15 back to 0.
        applyStimulus(16'h8000, 1'b0);
        waitGrant(waited);
        checkOutput("wrap_first_select", select, 15);
        expectGrant(15, 1, 0);
        applyStimulus(16'h8001, 1'b1);
        tick();
        applyStimulus(16'h8001, 1'b0);
        waitGrant(waited);
        checkOutput("wrap_select", select, 0);
        expectGrant(0, 1, 0);
        applyStimulus(16'h0000, 1'b1);
        tick();
        applyStimulus(16'h0000, 1'b0);

        // Hold timeout with HOLD_MAX=4 and a lone requester.
        applyStimulus(16'h0008, 1'b0);
        waitGrant(waited);
        checkOutput("tmo_select", select, 3);
        expectGrant(3, 4, 4);
        repeat (4) tick();
        checkOutput("tmo_released_grant_valid", grant_valid, 0);
        checkOutput("tmo_released_timeout", timeout, 0);
        waitGrant(waited);
        checkOutput("tmo_regrant_gap", waited, 2);
        checkOutput("tmo_regrant_select", select, 3);

        // done coinciding with the last allowed cycle still counts as a timeout.
        expectGrant(3, 4, 4);
        repeat (3) tick();
        checkOutput("tmo_pulse_visible", timeout, 1);
        applyStimulus(16'h0008, 1'b1);
        tick();
        applyStimulus(16'h0008, 1'b0);

        // Holder withdraws without done: plain release.
        waitGrant(waited);
        checkOutput("drop_select", select, 3);
        expectGrant(3, 2, 0);
        tick();
        applyStimulus(16'h0000, 1'b0);
        tick();
        checkOutput("drop_grant_valid", grant_valid, 0);
        checkOutput("drop_timeout", timeout, 0);

        // No requests: no grant for 50 cycles.
        any_gv = 1'b0;
        repeat (50) begin
            tick();
            if (grant_valid) any_gv = 1'b1;
        end
        checkOutput("idle_no_grant", any_gv, 0);

        // HOLD_MAX=0 instance: grant lasts until done.
        req_b  = 16'h0002;
        waited = 0;
        while (!grant_valid_b && waited < 40) begin
            tick();
            waited++;
        end
        checkOutput("nohold_grant_valid", grant_valid_b, 1);
        checkOutput("nohold_select", select_b, 1);
        bad_gv  = 1'b0;
        bad_tmo = 1'b0;
        bad_sel = 1'b0;
        repeat (40) begin
            tick();
            if (!grant_valid_b) bad_gv = 1'b1;
            if (timeout_b) bad_tmo = 1'b1;
            if (select_b != 4'd1) bad_sel = 1'b1;
        end
        checkOutput("nohold_grant_held", bad_gv, 0);
        checkOutput("nohold_no_timeout", bad_tmo, 0);
        checkOutput("nohold_select_stable", bad_sel, 0);
        req_b  = 16'h0000;
        done_b = 1'b1;
        tick();
        done_b = 1'b0;
        checkOutput("nohold_released", grant_valid_b, 0);

        repeat (3) tick();
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
